video_burst_writer: RTL and testbench

// - Downstream consumer of the video sampling buffer (256-bit read port, 2^RD_ADDR_LEN words, two halves).
// - When the sampler raises data_out_ready, reads one half-buffer (BURST_LEN words) and sends it to DDR as one AXI write burst.
// - Tracks the per-frame DDR write pointer and restarts it on frame end. Sits between video_sampling_* and the DDR AXI port.

---
 rtl/video_burst_writer.sv | 192 +++++++++++++++++++
 tb/tb_video_burst_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_burst_writer.sv
// video_burst_writer: drains one half of the video sampling buffer per
// data_out_ready into a single 16-beat AXI write burst. It tracks the
// per-frame DDR write pointer and restarts it on frame end.
// Optional feature macro: FRAME_PINGPONG_EN (frames alternate between two DDR banks).
module video_burst_writer #(
  parameter int unsigned            RD_ADDR_LEN = 5,
  parameter int unsigned            DQ_WIDTH    = 32,
  parameter int unsigned            ADDR_WIDTH  = 28,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter logic [ADDR_WIDTH-1:0]  FRAME_BYTES = ADDR_WIDTH'(32'h0007_0800)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    buf_ready,
  input  logic [3:0]              buf_trans_id,
  input  logic                    buf_frame_end,
  output logic                    buf_rd_valid,
  output logic [RD_ADDR_LEN-1:0]  buf_rd_addr,
  input  logic [DQ_WIDTH*8-1:0]   buf_rd_data,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [3:0]              axi_awid,
  output logic [3:0]              axi_awlen,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DQ_WIDTH*8-1:0]   axi_wdata,
  output logic [DQ_WIDTH-1:0]     axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int unsigned BURST_LEN = 1 << (RD_ADDR_LEN - 1);
  localparam logic [RD_ADDR_LEN-1:0] RD_END      = RD_ADDR_LEN'(BURST_LEN);
  localparam logic [RD_ADDR_LEN-2:0] LAST_BEAT   = '1;
  localparam logic [ADDR_WIDTH-1:0]  BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DQ_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_half;
  logic                    r_frame_pend;
  logic                    r_frame_done;
  logic                    r_rd_valid;
  logic [3:0]              r_awid;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [RD_ADDR_LEN-1:0]  r_beat_rd;
  logic [RD_ADDR_LEN-2:0]  r_beat_wr;
  logic                    r_inflight;
  logic [1:0]              r_occ;
  logic [DQ_WIDTH*8-1:0]   r_sk0;
  logic [DQ_WIDTH*8-1:0]   r_sk1;
  logic                    w_bank;
  logic                    w_room;
  logic                    w_issue;
  logic                    w_pop;
  logic                    w_wlast_hs;
  logic                    w_frame_clr;
  logic [ADDR_WIDTH-1:0]   w_ptr_inc;

  // Room check counts the read already in flight, so the 2-entry skid never overflows.
  assign w_room      = (r_occ == 2'd0) || ((r_occ == 2'd1) && !r_inflight);
  assign w_issue     = ((r_state == S_ADDR) || (r_state == S_DATA)) && (r_beat_rd < RD_END) && w_room;
  assign w_pop       = axi_wvalid && axi_wready;
  assign w_wlast_hs  = w_pop && (r_beat_wr == LAST_BEAT);
  assign w_frame_clr = r_frame_pend || buf_frame_end;
  assign w_ptr_inc   = r_wr_ptr + BURST_BYTES;

  assign buf_rd_valid = r_rd_valid;
  assign buf_rd_addr  = {r_half, r_beat_rd[RD_ADDR_LEN-2:0]};
  assign axi_awaddr   = BASE_ADDR + (w_bank ? FRAME_BYTES : '0) + r_wr_ptr;
  assign axi_awid     = r_awid;
  assign axi_awlen    = 4'(BURST_LEN - 1);
  assign axi_awvalid  = (r_state == S_ADDR);
  assign axi_wdata    = r_sk0;
  assign axi_wstrb    = '1;
  assign axi_wvalid   = (r_state == S_DATA) && (r_occ != 2'd0);
  assign axi_wlast    = (r_state == S_DATA) && (r_beat_wr == LAST_BEAT);
  assign frame_done   = r_frame_done;
  assign busy         = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: one burst per buf_ready sampled in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (buf_ready) w_state_nxt = S_ADDR;
      S_ADDR:  if (axi_awready) w_state_nxt = S_DATA;
      S_DATA:  if (w_wlast_hs) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst start, AXI ID latch and read/write beat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_awid     <= '0;
      r_beat_rd  <= '0;
      r_beat_wr  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == S_IDLE) && buf_ready;
      r_inflight <= w_issue;
      if ((r_state == S_IDLE) && buf_ready) begin
        r_awid    <= buf_trans_id;
        r_beat_rd <= '0;
        r_beat_wr <= '0;
      end else begin
        if (w_issue) r_beat_rd <= r_beat_rd + 1'b1;
        if (w_pop)   r_beat_wr <= r_beat_wr + 1'b1;
      end
    end
  end

  // Skid buffer: r_sk0 is the head presented on W and only moves on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
      r_sk0 <= '0;
      r_sk1 <= '0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_sk0 <= buf_rd_data;
          else               r_sk1 <= buf_rd_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_sk0 <= r_sk1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_sk0 <= buf_rd_data;
          end else begin
            r_sk0 <= r_sk1;
            r_sk1 <= buf_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame bookkeeping: a pending frame end beats the pointer increment in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_half       <= 1'b0;
      r_frame_pend <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (r_state == S_DONE) begin
      if (w_frame_clr) begin
        r_wr_ptr     <= '0;
        r_half       <= 1'b0;
        r_frame_pend <= 1'b0;
        r_frame_done <= 1'b1;
      end else begin
        r_wr_ptr     <= (w_ptr_inc >= FRAME_BYTES) ? '0 : w_ptr_inc;
        r_half       <= ~r_half;
        r_frame_done <= 1'b0;
      end
    end else begin
      r_frame_pend <= r_frame_pend | buf_frame_end;
      r_frame_done <= 1'b0;
    end
  end

`ifdef FRAME_PINGPONG_EN
  logic r_bank;

  // Bank flips with every completed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_bank <= 1'b0;
    else if (r_frame_done) r_bank <= ~r_bank;
  end

  assign w_bank = r_bank;
`else
  assign w_bank = 1'b0;
`endif

endmodule

// File: tb/tb_video_burst_writer.sv
// Bench for video_burst_writer: randomized AW/W backpressure against a
// frame-level reference model (half/pointer/bank bookkeeping and buffer contents).
module tb_video_burst_writer;

  localparam logic [27:0] TB_FRAME = 28'h001C200;

  logic         clk = 1'b0;
  logic         rst;
  logic         buf_ready;
  logic [3:0]   buf_trans_id;
  logic         buf_frame_end;
  logic         buf_rd_valid;
  logic [4:0]   buf_rd_addr;
  logic [255:0] buf_rd_data;
  logic [27:0]  axi_awaddr;
  logic [3:0]   axi_awid;
  logic [3:0]   axi_awlen;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready;
  logic         frame_done;
  logic         busy;

  video_burst_writer #(
    .RD_ADDR_LEN (5),
    .DQ_WIDTH    (32),
    .ADDR_WIDTH  (28),
    .BASE_ADDR   (28'h0),
    .FRAME_BYTES (TB_FRAME)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .buf_ready     (buf_ready),
    .buf_trans_id  (buf_trans_id),
    .buf_frame_end (buf_frame_end),
    .buf_rd_valid  (buf_rd_valid),
    .buf_rd_addr   (buf_rd_addr),
    .buf_rd_data   (buf_rd_data),
    .axi_awaddr    (axi_awaddr),
    .axi_awid      (axi_awid),
    .axi_awlen     (axi_awlen),
    .axi_awvalid   (axi_awvalid),
    .axi_awready   (axi_awready),
    .axi_wdata     (axi_wdata),
    .axi_wstrb     (axi_wstrb),
    .axi_wlast     (axi_wlast),
    .axi_wvalid    (axi_wvalid),
    .axi_wready    (axi_wready),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Sampler buffer model: registered read, data one cycle after the address.
  logic [255:0] mem [32];
  always @(posedge clk) buf_rd_data <= mem[buf_rd_addr];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state.
  int unsigned m_half = 0;
  int unsigned m_bank = 0;
  bit          m_pend = 1'b0;
  logic [27:0] m_ptr  = '0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [27:0] exp_addr();
    return ((m_bank != 0) ? TB_FRAME : 28'h0) + m_ptr;
  endfunction

  // aw_mode: 0 ready, 1 low for 10 cycles, 2 random.
  // w_mode: 0 ready, 1 toggling, 2 random, 3 toggling with a 5-cycle stall.
  task automatic run_burst(input logic [3:0] id, input int aw_mode, input int w_mode,
                           input int fe_beat, input bit fe_done, input int rst_beat);
    logic [27:0]  aw_exp;
    logic [255:0] hold_data;
    logic [255:0] exp_word;
    bit           hold = 1'b0;
    bit           aw_done = 1'b0;
    bit           fe_sent = 1'b0;
    int           beat = 0;
    int           cyc = 0;
    int           aw_wait = 0;

    @(negedge clk);
    buf_ready = 1'b1; buf_trans_id = id; axi_awready = 1'b0; axi_wready = 1'b0;
    #1 check("idle_busy", busy, 0);
    @(negedge clk);
    buf_ready = 1'b0; buf_trans_id = 4'($urandom);
    #1;
    check("rd_valid", buf_rd_valid, 1);
    check("awid", axi_awid, id);
    check("awvalid_start", axi_awvalid, 1);
    check("rd_addr_start", buf_rd_addr, 5'(m_half * 16));
    aw_exp = exp_addr();
    check("awaddr", axi_awaddr, aw_exp);

    while (beat < 16 && cyc < 400) begin
      if (rst_beat >= 0 && beat == rst_beat) begin
        rst = 1'b1;
        #1;
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_busy", busy, 0);
        m_half = 0; m_ptr = '0; m_bank = 0; m_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0;
        return;
      end
      case (aw_mode)
        0:       axi_awready = 1'b1;
        1:       axi_awready = (aw_wait >= 10);
        default: axi_awready = 1'($urandom_range(0, 1));
      endcase
      case (w_mode)
        0:       axi_wready = 1'b1;
        1:       axi_wready = (cyc % 2 == 0);
        2:       axi_wready = 1'($urandom_range(0, 1));
        default: axi_wready = (cyc >= 8 && cyc < 13) ? 1'b0 : (cyc % 2 == 0);
      endcase
      buf_frame_end = (beat == fe_beat) && !fe_sent;
      if (buf_frame_end) begin
        fe_sent = 1'b1;
        m_pend  = 1'b1;
      end
      if (axi_awvalid) begin
        check("awaddr_hold", axi_awaddr, aw_exp);
        aw_wait++;
      end
      if (axi_wvalid) begin
        check("w_after_aw", aw_done, 1);
        if (hold) check("wdata_stable", axi_wdata, hold_data);
        exp_word = mem[m_half * 16 + beat];
        check("wdata", axi_wdata, exp_word);
        check("wlast", axi_wlast, (beat == 15));
        if (axi_wready) begin
          beat++;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          hold_data = axi_wdata;
        end
      end else if (hold) begin
        check("wvalid_held", axi_wvalid, 1);
        hold = 1'b0;
      end
      if (axi_awvalid && axi_awready) aw_done = 1'b1;
      @(negedge clk);
      #1;
      cyc++;
    end
    check("burst_beats", beat, 16);

    // DONE cycle.
    axi_awready = 1'b0; axi_wready = 1'b0;
    buf_frame_end = fe_done;
    if (fe_done) m_pend = 1'b1;
    check("done_busy", busy, 1);
    check("done_wvalid", axi_wvalid, 0);
    check("done_frame_done", frame_done, 0);
    @(negedge clk);
    buf_frame_end = 1'b0;
    #1;
    check("idle_after_done", busy, 0);
    check("frame_done", frame_done, m_pend);
    if (m_pend) begin
      m_pend = 1'b0; m_ptr = '0; m_half = 0;
`ifdef FRAME_PINGPONG_EN
      m_bank = 1 - m_bank;
`endif
    end else begin
      m_half = 1 - m_half;
      m_ptr  = (m_ptr + 28'd512 >= TB_FRAME) ? 28'h0 : m_ptr + 28'd512;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 8; j++)
        mem[i][j*32 +: 32] = $urandom();
    rst = 1'b1; buf_ready = 1'b0; buf_trans_id = '0; buf_frame_end = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_awvalid0", axi_awvalid, 0);
    check("rst_wvalid0", axi_wvalid, 0);
    check("rst_wlast0", axi_wlast, 0);
    check("rst_busy0", busy, 0);
    check("rst_rd_valid0", buf_rd_valid, 0);
    check("rst_frame_done0", frame_done, 0);
    check("rst_awlen", axi_awlen, 15);
    check("rst_wstrb", axi_wstrb, 32'hFFFF_FFFF);
    check("rst_awaddr", axi_awaddr, 0);
    @(negedge clk);
    rst = 1'b0;

    run_burst(4'd5, 0, 0, -1, 1'b0, -1);
    run_burst(4'd9, 0, 0, -1, 1'b0, -1);
    run_burst(4'd2, 0, 0, -1, 1'b0, -1);
    run_burst(4'd3, 0, 1, -1, 1'b0, -1);
    run_burst(4'd7, 0, 3, -1, 1'b0, -1);
    run_burst(4'd1, 1, 2, -1, 1'b0, -1);
    for (int k = 0; k < 4; k++)
      run_burst(4'($urandom), 2, 2, -1, 1'b0, -1);

    // Frame end mid-burst, then on a later DONE cycle, then while idle.
    run_burst(4'hA, 0, 2, 4, 1'b0, -1);
    run_burst(4'hB, 2, 0, -1, 1'b0, -1);
    run_burst(4'hC, 0, 1, -1, 1'b1, -1);
    run_burst(4'hD, 0, 0, -1, 1'b0, -1);
    @(negedge clk);
    buf_frame_end = 1'b1; m_pend = 1'b1;
    @(negedge clk);
    buf_frame_end = 1'b0;
    run_burst(4'hE, 2, 2, -1, 1'b0, -1);

    // Reset at beat 7, then a clean burst from the frame start.
    run_burst(4'h6, 0, 2, -1, 1'b0, 7);
    run_burst(4'h4, 0, 0, -1, 1'b0, -1);

    // Walk the pointer through its overflow wrap.
    for (int k = 0; k < 228; k++)
      run_burst(4'($urandom), 0, 0, -1, 1'b0, -1);
    for (int k = 0; k < 3; k++)
      run_burst(4'($urandom), 2, 2, -1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
